// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the clock-divider configuration controller.
package clk_div_ctrl_pkg;

  localparam int NUM_REQ = 2;
  localparam int RATIO_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATE   = 2'd1,
    ST_LOAD   = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/clk_div_cfg_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester favoured on a tie.
module rr_arb2
  import clk_div_ctrl_pkg::*;
(
  input  logic               i_ref_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_ptr
);

  logic ptr_q, ptr_d;

  always_comb begin
    o_grant = '0;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = ptr_q ? 2'b10 : 2'b01;
      default: o_grant = '0;
    endcase
  end

  // Moving past the winner: a requester-0 win favours requester 1 next, and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (i_advance) ptr_d = o_grant[0];
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Arbitrates ratio-change requests and sequences each change glitch-free:
// gate the enable, quiesce, load the ratio, settle, re-enable.
module clk_div_cfg_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter logic [RATIO_W-1:0] RESET_RATIO = 8'd8,
  parameter logic [RATIO_W-1:0] MAX_RATIO   = 8'd63,
  parameter int                 QUIESCE     = 4,
  parameter int                 SETTLE      = 2
) (
  input  logic               i_ref_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [RATIO_W-1:0] i_ratio0,
  input  logic [RATIO_W-1:0] i_ratio1,
  output logic [NUM_REQ-1:0] o_ack,
  output logic [NUM_REQ-1:0] o_err,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic               o_clk_en,
  output logic               o_busy
);

  localparam int CNT_MAX = (QUIESCE > SETTLE) ? QUIESCE : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] QUIESCE_LOAD = CNT_W'(QUIESCE - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RATIO_W-1:0]   ratio_q, ratio_d;
  logic [RATIO_W-1:0]   div_ratio_q, div_ratio_d;
  logic                 clk_en_q, clk_en_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   err_q, err_d;

  logic [NUM_REQ-1:0]   req_eff;
  logic [NUM_REQ-1:0]   grant;
  logic                 grant_valid;
  logic                 arb_ptr;
  logic [RATIO_W-1:0]   win_ratio;

  // A requester still holds its request during its own ack/err cycle, so mask it off.
  assign req_eff     = i_req & ~(ack_q | err_q);
  assign grant_valid = (state_q == ST_IDLE) && (req_eff != '0);
  assign win_ratio   = grant[1] ? i_ratio1 : i_ratio0;

  rr_arb2 u_arb (
    .i_ref_clk (i_ref_clk),
    .i_rst     (i_rst),
    .i_req     (req_eff),
    .i_advance (grant_valid),
    .o_grant   (grant),
    .o_ptr     (arb_ptr)
  );

  // The pointer only moves on grants, so during a sequence it points away from the owner.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ratio_d     = ratio_q;
    div_ratio_d = div_ratio_q;
    clk_en_d    = clk_en_q;
    ack_d       = '0;
    err_d       = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          ratio_d = win_ratio;
          if (win_ratio > MAX_RATIO) begin
            err_d = grant;
          end else if ((win_ratio == div_ratio_q) && clk_en_q) begin
            ack_d = grant;
          end else begin
            clk_en_d = 1'b0;
            cnt_d    = QUIESCE_LOAD;
            state_d  = ST_GATE;
          end
        end
      end
      ST_GATE: begin
        if (cnt_q == '0) state_d = ST_LOAD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_LOAD: begin
        div_ratio_d = ratio_q;
        cnt_d       = SETTLE_LOAD;
        state_d     = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          clk_en_d = 1'b1;
          ack_d    = req_onehot(~arb_ptr);
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ratio_q     <= RESET_RATIO;
      div_ratio_q <= RESET_RATIO;
      clk_en_q    <= 1'b1;
      ack_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      div_ratio_q <= div_ratio_d;
      clk_en_q    <= clk_en_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  assign o_ack       = ack_q;
  assign o_err       = err_q;
  assign o_div_ratio = div_ratio_q;
  assign o_clk_en    = clk_en_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl; cycle k is observed at the falling edge after rising edge k-1.
module tb_clk_div_cfg_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [7:0] ratio0;
  logic [7:0] ratio1;
  logic [1:0] ack;
  logic [1:0] err;
  logic [7:0] divRatio;
  logic       clkEn;
  logic       busy;

  int checks = 0;
  int errors = 0;

  clk_div_cfg_ctrl dut (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_ratio0    (ratio0),
    .i_ratio1    (ratio1),
    .o_ack       (ack),
    .o_err       (err),
    .o_div_ratio (divRatio),
    .o_clk_en    (clkEn),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] expAck, input logic [1:0] expErr,
                          input logic [7:0] expDiv, input logic expEn, input logic expBusy);
    checkOutput({tag, " ack"},  {6'd0, ack},   {6'd0, expAck});
    checkOutput({tag, " err"},  {6'd0, err},   {6'd0, expErr});
    checkOutput({tag, " div"},  divRatio,      expDiv);
    checkOutput({tag, " en"},   {7'd0, clkEn}, {7'd0, expEn});
    checkOutput({tag, " busy"}, {7'd0, busy},  {7'd0, expBusy});
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [7:0] r0, input logic [7:0] r1);
    req    = r;
    ratio0 = r0;
    ratio1 = r1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(2'b00, 8'd0, 8'd0);
    #1;
    checkAll("reset async", 2'b00, 2'b00, 8'd8, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: values hold with no requests
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkAll($sformatf("idle c%0d", k), 2'b00, 2'b00, 8'd8, 1'b1, 1'b0);
    end

    // Fast path: requester 1 asks for the current ratio 8
    applyStimulus(2'b10, 8'd0, 8'd8);
    @(negedge clk);
    checkAll("fast8 c1", 2'b10, 2'b00, 8'd8, 1'b1, 1'b0);
    @(negedge clk);
    checkAll("fast8 c2", 2'b00, 2'b00, 8'd8, 1'b1, 1'b0);
    applyStimulus(2'b00, 8'd0, 8'd8);
    @(negedge clk);
    checkAll("fast8 c3", 2'b00, 2'b00, 8'd8, 1'b1, 1'b0);

    // Normal change: requester 0 asks for 12
    applyStimulus(2'b01, 8'd12, 8'd0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checkAll($sformatf("r12 c%0d", k), (k == 8) ? 2'b01 : 2'b00, 2'b00,
               (k >= 6) ? 8'd12 : 8'd8, !(k >= 1 && k <= 7), (k >= 1 && k <= 7));
    end
    applyStimulus(2'b00, 8'd12, 8'd0);

    // Rejected ratio: requester 1 asks for 64
    @(negedge clk);
    applyStimulus(2'b10, 8'd0, 8'd64);
    @(negedge clk);
    checkAll("err64 c1", 2'b00, 2'b10, 8'd12, 1'b1, 1'b0);
    @(negedge clk);
    checkAll("err64 c2", 2'b00, 2'b00, 8'd12, 1'b1, 1'b0);
    applyStimulus(2'b00, 8'd0, 8'd64);
    @(negedge clk);

    // Reset during SETTLE discards the in-flight request
    applyStimulus(2'b01, 8'd20, 8'd0);
    for (int k = 1; k <= 6; k++) @(negedge clk);
    checkAll("rst20 settle", 2'b00, 2'b00, 8'd20, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    checkAll("rst20 async", 2'b00, 2'b00, 8'd8, 1'b1, 1'b0);
    applyStimulus(2'b00, 8'd20, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkAll($sformatf("rst20 hold%0d", k), 2'b00, 2'b00, 8'd8, 1'b1, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(2'b10, 8'd0, 8'd30);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checkAll($sformatf("r30 c%0d", k), (k == 8) ? 2'b10 : 2'b00, 2'b00,
               (k >= 6) ? 8'd30 : 8'd8, !(k >= 1 && k <= 7), (k >= 1 && k <= 7));
    end
    applyStimulus(2'b00, 8'd0, 8'd30);
    @(negedge clk);

    // Both request: requester 0 first, requester 1 granted as the ack cycle ends
    applyStimulus(2'b11, 8'd4, 8'd6);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      checkAll($sformatf("pair1 c%0d", k),
               (k == 8) ? 2'b01 : ((k == 16) ? 2'b10 : 2'b00), 2'b00,
               (k < 6) ? 8'd30 : ((k < 14) ? 8'd4 : 8'd6),
               !((k >= 1 && k <= 7) || (k >= 9 && k <= 15)),
               (k >= 1 && k <= 7) || (k >= 9 && k <= 15));
      if (k == 9)  req[0] = 1'b0;
      if (k == 17) req[1] = 1'b0;
    end

    // Requester 0 alone hits the fast path, which still moves the pointer
    applyStimulus(2'b01, 8'd6, 8'd0);
    @(negedge clk);
    checkAll("fast6 c1", 2'b01, 2'b00, 8'd6, 1'b1, 1'b0);
    @(negedge clk);
    checkAll("fast6 c2", 2'b00, 2'b00, 8'd6, 1'b1, 1'b0);
    applyStimulus(2'b00, 8'd6, 8'd0);
    @(negedge clk);

    // Pair again: requester 1 now wins (fast path at 6), then requester 0 loads 4
    applyStimulus(2'b11, 8'd4, 8'd6);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checkAll($sformatf("pair2 c%0d", k),
               (k == 1) ? 2'b10 : ((k == 9) ? 2'b01 : 2'b00), 2'b00,
               (k < 7) ? 8'd6 : 8'd4, !(k >= 2 && k <= 8), (k >= 2 && k <= 8));
      if (k == 2)  req[1] = 1'b0;
      if (k == 10) req[0] = 1'b0;
    end
    repeat (2) @(negedge clk);
    checkAll("final idle", 2'b00, 2'b00, 8'd4, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
